// File: rtl/uart_command_frame_rx.sv
// uart_command_frame_rx
//   Assembles UART bytes into 5-byte command frames (HEAD0 HEAD1 CMD VAL CHK).
//   A frame is good when:
//     - CHK == CMD ^ VAL, and
//     - the upper nibbles of CMD and VAL are both zero.
//   Frame outcomes:
//     - Good frame: the ctrl/value nibbles update and O_command_flag pulses
//       one cycle after the CHK strobe.
//     - Bad frame: O_frame_err pulses instead.
//     - Inter-byte timeout inside a frame: O_frame_err pulses and the receiver
//       returns to hunting for HEAD0.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   I_rx_data[7:0]    received byte, qualified by I_rx_valid
//   I_rx_valid        one-cycle strobe per received byte
//   O_command_flag    one-cycle pulse: good frame, nibbles valid this cycle
//   O_ctrl_command    ctrl nibble of last good frame (CMD[3:0])
//   O_value_command   value nibble of last good frame (VAL[3:0])
//   O_frame_err       one-cycle pulse: checksum/reserved-bit error or timeout
module uart_command_frame_rx #(
    parameter logic [7:0] P_HEAD0   = 8'h55,
    parameter logic [7:0] P_HEAD1   = 8'hAA,
    parameter int         P_TIMEOUT = 1_000_000,
    parameter int         P_TO_W    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] I_rx_data,
    input  logic       I_rx_valid,
    output logic       O_command_flag,
    output logic [3:0] O_ctrl_command,
    output logic [3:0] O_value_command,
    output logic       O_frame_err
);

    typedef enum logic [2:0] {S_HEAD0, S_HEAD1, S_CMD, S_VAL, S_CHK} state_t;

    localparam logic [P_TO_W-1:0] TO_MAX = P_TO_W'(P_TIMEOUT);

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        val_q, val_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [3:0]        value_q, value_d;
    logic              flag_q, flag_d;
    logic              err_q, err_d;
    logic [P_TO_W-1:0] to_cnt_q, to_cnt_d;
    logic              timeout;

    // A strobe in the same cycle as a saturated counter takes priority.
    assign timeout = !I_rx_valid && (state_q != S_HEAD0) && (to_cnt_q == TO_MAX);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        val_d   = val_q;
        ctrl_d  = ctrl_q;
        value_d = value_q;
        flag_d  = 1'b0;
        err_d   = 1'b0;
        if (I_rx_valid) begin
            unique case (state_q)
                S_HEAD0: if (I_rx_data == P_HEAD0) state_d = S_HEAD1;
                S_HEAD1: begin
                    // A repeated HEAD0 keeps us waiting for HEAD1 (resync).
                    if (I_rx_data == P_HEAD1)      state_d = S_CMD;
                    else if (I_rx_data != P_HEAD0) state_d = S_HEAD0;
                end
                S_CMD: begin
                    cmd_d   = I_rx_data;
                    state_d = S_VAL;
                end
                S_VAL: begin
                    val_d   = I_rx_data;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    state_d = S_HEAD0;
                    if (I_rx_data == (cmd_q ^ val_q) &&
                        cmd_q[7:4] == 4'h0 && val_q[7:4] == 4'h0) begin
                        flag_d  = 1'b1;
                        ctrl_d  = cmd_q[3:0];
                        value_d = val_q[3:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = S_HEAD0;
            endcase
        end else if (timeout) begin
            state_d = S_HEAD0;
            err_d   = 1'b1;
        end
    end

    // Inter-byte timer: idle while hunting for HEAD0, restarted by each byte.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (I_rx_valid || state_q == S_HEAD0 || timeout) to_cnt_d = '0;
        else if (to_cnt_q != TO_MAX)                      to_cnt_d = to_cnt_q + P_TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HEAD0;
            cmd_q    <= '0;
            val_q    <= '0;
            ctrl_q   <= '0;
            value_q  <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            val_q    <= val_d;
            ctrl_q   <= ctrl_d;
            value_q  <= value_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign O_command_flag  = flag_q;
    assign O_frame_err     = err_q;
    assign O_ctrl_command  = ctrl_q;
    assign O_value_command = value_q;

endmodule
